// File: rtl/nibble_serial_addsub.sv
// Multi-word add/subtract: one 4-bit ripple slice reused for WIDTH/4 clocks, LSB nibble
// first, with the inter-nibble carry held in a register and a start/done handshake.
module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    generate
        if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    // One ripple slice; returns {carry out, carry into bit 3, nibble sum}.
    function automatic logic [5:0] nib_add(input logic [3:0] a, input logic [3:0] b,
                                           input logic cin);
        logic [3:0] lo;
        logic [4:0] full;
        lo   = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
        full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        return {full[4], lo[3], full[3:0]};
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CNT_W+1:0] shamt;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [5:0]       add_r;
    logic             accept;
    logic             last;

    assign accept = Start && (state_q != RUN);
    assign last   = (cnt_q == LAST);
    assign shamt  = {cnt_q, 2'b00};
    assign nib_a  = 4'(opa_q >> shamt);
    assign nib_b  = 4'(opb_q >> shamt);
    assign add_r  = nib_add(nib_a, nib_b, carry_q);

    // Result with nibble k replaced by this cycle's slice output.
    assign res_d = (res_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(add_r[3:0]) << shamt);

    // Control and visible outputs: async reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    carry_q <= add_r[5];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= res_d;
                        cout_q  <= add_r[5];
                        ovf_q   <= add_r[4] ^ add_r[5];
                    end
                end
                default: begin
                    if (Start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        // Subtract is A + ~B + 1, the +1 entering as the initial carry.
                        carry_q <= Sub;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // Operand and partial-result storage; only meaningful while an operation runs.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa_q <= A;
            opb_q <= Sub ? ~B : B;
        end
        if (state_q == RUN) begin
            res_q <= res_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench: WIDTH=16 and WIDTH=4 instances against a cycle-level arithmetic model.
module tb_nibble_serial_addsub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        Busy16, Done16, Cout16, Ovf16;
    logic [15:0] Sum16;
    logic        st4 = 1'b0, sub4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        Busy4, Done4, Cout4, Ovf4;
    logic [3:0]  Sum4;

    int n_chk  = 0;
    int n_pass = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    nibble_serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .Start(st16), .Sub(sub16), .A(a16), .B(b16),
        .Busy(Busy16), .Done(Done16), .Sum(Sum16), .Cout(Cout16), .Ovf(Ovf16));

    nibble_serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .Start(st4), .Sub(sub4), .A(a4), .B(b4),
        .Busy(Busy4), .Done(Done4), .Sum(Sum4), .Cout(Cout4), .Ovf(Ovf4));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Plain integer arithmetic: returns {cout, ovf, sum}.
    function automatic logic [17:0] compute(input int w, input logic sub,
                                            input logic [15:0] a, input logic [15:0] b);
        longint m, half, ua, ub, r, sa, sb, sr;
        logic c, o;
        m    = longint'(1) << w;
        half = m / 2;
        ua   = longint'(a) & (m - 1);
        ub   = longint'(b) & (m - 1);
        if (sub) begin r = ua - ub; c = (ua >= ub); end
        else     begin r = ua + ub; c = (r >= m);   end
        sa = (ua >= half) ? ua - m : ua;
        sb = (ub >= half) ? ub - m : ub;
        sr = sub ? sa - sb : sa + sb;
        o  = (sr >= half) || (sr < -half);
        return {c, o, 16'(r & (m - 1))};
    endfunction

    typedef struct {
        logic        busy, done, cout, ovf;
        logic [15:0] sum;
        int          left;
        logic [17:0] pend;
    } mstate_t;

    mstate_t m16 = '{default: 0};
    mstate_t m4  = '{default: 0};

    function automatic mstate_t step(input mstate_t m, input int w, input logic st,
                                     input logic sub, input logic [15:0] a, input logic [15:0] b);
        m.done = 1'b0;
        if (m.busy) begin
            m.left--;
            if (m.left == 0) begin
                {m.cout, m.ovf, m.sum} = m.pend;
                m.done = 1'b1;
                m.busy = 1'b0;
            end
        end else if (st) begin
            m.pend = compute(w, sub, a, b);
            m.busy = 1'b1;
            m.left = w / 4;
        end
        return m;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m16 = '{default: 0};
            m4  = '{default: 0};
        end else begin
            m16 = step(m16, 16, st16, sub16, a16, b16);
            m4  = step(m4, 4, st4, sub4, {12'h0, a4}, {12'h0, b4});
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("cycle16", {Busy16, Done16, Cout16, Ovf16, Sum16},
                  {m16.busy, m16.done, m16.cout, m16.ovf, m16.sum});
            check("cycle4", {Busy4, Done4, Cout4, Ovf4, Sum4},
                  {m4.busy, m4.done, m4.cout, m4.ovf, m4.sum[3:0]});
        end
    end

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic glitch, input logic [15:0] es, input logic ec,
                         input logic eo, input string nm);
        int busy_n = 0;
        int done_at = 0;
        logic [15:0] gs = 'x;
        logic gc = 1'bx, go = 1'bx;
        @(negedge clk);
        a16 = a; b16 = b; sub16 = sub; st16 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) st16 = 1'b0;
            if (glitch && i == 2) begin
                st16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b1;
            end
            if (glitch && i == 3) st16 = 1'b0;
            if (Busy16) busy_n++;
            if (Done16 && done_at == 0) begin
                done_at = i; gs = Sum16; gc = Cout16; go = Ovf16;
            end
        end
        check({nm, " latency"}, done_at, 5);
        check({nm, " busy"}, busy_n, 4);
        check({nm, " sum"}, gs, es);
        check({nm, " cout/ovf"}, {gc, go}, {ec, eo});
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sub);
        logic [17:0] e;
        logic got = 1'b0;
        logic [5:0] r = 'x;
        @(negedge clk);
        a4 = a; b4 = b; sub4 = sub; st4 = 1'b1;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (i == 1) st4 = 1'b0;
            if (Done4) begin got = 1'b1; r = {Cout4, Ovf4, Sum4}; end
        end
        e = compute(4, sub, {12'h0, a}, {12'h0, b});
        check("sweep4", {got, r}, {1'b1, e[17:16], e[3:0]});
    endtask

    initial begin
        int dq[$];
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dq[$];
        repeat (3) @(negedge clk);
        check("reset16", {Busy16, Done16, Cout16, Ovf16, Sum16}, 0);
        check("reset4", {Busy4, Done4, Cout4, Ovf4, Sum4}, 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        check("pin add16", compute(16, 1'b0, 16'h1234, 16'h0FFF), {2'b00, 16'h2233});
        check("pin sub16", compute(16, 1'b1, 16'h8000, 16'h0001), {2'b11, 16'h7FFF});
        check("pin sub4", compute(4, 1'b1, 16'h0, 16'h1), {2'b00, 16'h000F});
        check("pin add4", compute(4, 1'b0, 16'h7, 16'h1), {2'b01, 16'h0008});

        run16(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, "add");
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add carry");
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add ovf");
        run16(16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, "sub borrow");
        run16(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, "sub ovf");
        run16(16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, "start ignored");

        @(negedge clk);
        a16 = 16'h0001; b16 = 16'h0002; sub16 = 1'b0; st16 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (Done16) dq.push_back(i);
        end
        st16 = 1'b0;
        check("b2b count", dq.size(), 4);
        for (int j = 0; j < dq.size(); j++) check("b2b spacing", dq[j], 5 * (j + 1));
        check("b2b sum", Sum16, 16'h0003);
        repeat (4) @(negedge clk);

        a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; st16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("abort outputs", {Busy16, Done16, Cout16, Ovf16, Sum16}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort no done", {Done16, Busy16}, 0);
        end
        run16(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, "after abort");

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run4(4'(a), 4'(b), s[0]);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
